// File: rtl/decoder_3to8_hold.sv
// 3-to-8 one-hot decoder with a per-word hold time.
// An accepted code is shown as a one-hot word for HOLD_CYCLES cycles; a new
// code may be accepted on the last hold cycle for gapless back-to-back words.
// Dropping enable aborts a hold; synchronous reset overrides everything.
module decoder_3to8_hold #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] code_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] decoded_out,
  output logic       out_valid
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       dec_n;
  logic             last_cycle;
  logic             accept;

  // Handshake: ready when idle or on the final cycle of a hold
  always_comb begin
    last_cycle = (state == HOLD) && (cnt == CNT_LAST);
    in_ready   = enable && !rst && ((state == IDLE) || last_cycle);
    accept     = in_valid && in_ready;
  end

  // Next-state, counter and output word selection
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dec_n   = decoded_out;
    if (accept) begin
      state_n = HOLD;
      cnt_n   = '0;
      dec_n   = 8'b0000_0001 << code_in;
    end else if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      dec_n   = '0;
    end else begin
      case (state)
        HOLD: begin
          if (last_cycle) begin
            state_n = IDLE;
            cnt_n   = '0;
            dec_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          dec_n   = '0;
        end
      endcase
    end
  end

  // State register with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      decoded_out <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      decoded_out <= dec_n;
    end
  end

  // Valid flag follows the word itself, so it can never disagree with it
  always_comb begin
    out_valid = |decoded_out;
  end

endmodule

// File: tb/tb_decoder_3to8_hold.sv
// Scoreboard bench for decoder_3to8_hold: one instance with HOLD_CYCLES=4 and
// one with HOLD_CYCLES=1 share the stimulus; each has its own expectation queue.
module tb_decoder_3to8_hold;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [2:0] code_in;
  logic       in_valid;
  logic       rdy4, ov4, rdy1, ov1;
  logic [7:0] dec4, dec1;

  typedef struct packed {
    logic       ready;
    logic [7:0] dec;
    logic [2:0] code;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic stim_done = 1'b0;

  decoder_3to8_hold #(.HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .enable(enable), .code_in(code_in),
    .in_valid(in_valid), .in_ready(rdy4), .decoded_out(dec4), .out_valid(ov4)
  );

  decoder_3to8_hold #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .code_in(code_in),
    .in_valid(in_valid), .in_ready(rdy1), .decoded_out(dec1), .out_valid(ov1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs and record what the selected DUT must show
  // during that cycle: ed = word currently displayed, er = in_ready now.
  // sel: 0 -> HOLD_CYCLES=4 instance, 1 -> HOLD_CYCLES=1 instance, 2 -> none.
  task automatic step(input int sel, input logic r, input logic e, input logic v,
                      input logic [2:0] c, input logic er, input logic [7:0] ed);
    exp_t x;
    @(negedge clk);
    rst      = r;
    enable   = e;
    in_valid = v;
    code_in  = c;
    x.ready  = er;
    x.dec    = ed;
    x.code   = '0;
    for (int i = 0; i < 8; i++) if (ed[i]) x.code = 3'(i);
    if (sel == 0) q4.push_back(x);
    else if (sel == 1) q1.push_back(x);
  endtask

  function automatic logic [3:0] prio_enc(input logic [7:0] d);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (d[i]) r = {1'b1, 3'(i)};
    return r;
  endfunction

  task automatic check(input string nm, input exp_t x, input logic rdy,
                       input logic [7:0] d, input logic ov);
    logic [3:0] pe;
    n_vec++;
    if (rdy !== x.ready) begin
      n_err++;
      $display("FAIL %s in_ready t=%0t got %b want %b", nm, $time, rdy, x.ready);
    end
    n_vec++;
    if (d !== x.dec) begin
      n_err++;
      $display("FAIL %s decoded_out t=%0t got %b want %b", nm, $time, d, x.dec);
    end
    n_vec++;
    if (ov !== (x.dec != 8'h00)) begin
      n_err++;
      $display("FAIL %s out_valid t=%0t got %b want %b", nm, $time, ov, (x.dec != 8'h00));
    end
    if (x.dec != 8'h00) begin
      pe = prio_enc(d);
      n_vec++;
      if (pe !== {1'b1, x.code}) begin
        n_err++;
        $display("FAIL %s loopback t=%0t got v=%b c=%0d want v=1 c=%0d",
                 nm, $time, pe[3], pe[2:0], x.code);
      end
    end
  endtask

  // Monitor: samples just after inputs settle each cycle and pops expectations
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (q4.size() > 0) begin
        x = q4.pop_front();
        check("h4", x, rdy4, dec4, ov4);
      end
      if (q1.size() > 0) begin
        x = q1.pop_front();
        check("h1", x, rdy1, dec1, ov1);
      end
    end
  end

  // Stimulus
  initial begin
    logic [2:0] codes[28];
    logic [7:0] one;
    one      = 8'b0000_0001;
    rst      = 1'b1;
    enable   = 1'b1;
    in_valid = 1'b1;
    code_in  = 3'd7;

    // Reset held for two edges with a pending code 7
    step(0, 1, 1, 1, 7, 0, 8'h00);
    step(0, 0, 1, 0, 7, 1, 8'h00);

    // Single word, code 3 held for 4 cycles
    step(0, 0, 1, 1, 3, 1, 8'h00);
    step(0, 0, 1, 0, 3, 0, 8'b0000_1000);
    step(0, 0, 1, 0, 3, 0, 8'b0000_1000);
    step(0, 0, 1, 0, 3, 0, 8'b0000_1000);
    step(0, 0, 1, 0, 3, 1, 8'b0000_1000);
    step(0, 0, 1, 0, 3, 1, 8'h00);

    // Back-to-back: code 7 then code 0 with in_valid held high
    step(0, 0, 1, 1, 7, 1, 8'h00);
    step(0, 0, 1, 1, 0, 0, 8'b1000_0000);
    step(0, 0, 1, 1, 0, 0, 8'b1000_0000);
    step(0, 0, 1, 1, 0, 0, 8'b1000_0000);
    step(0, 0, 1, 1, 0, 1, 8'b1000_0000);
    step(0, 0, 1, 0, 0, 0, 8'b0000_0001);
    step(0, 0, 1, 0, 0, 0, 8'b0000_0001);
    step(0, 0, 1, 0, 0, 0, 8'b0000_0001);
    step(0, 0, 1, 0, 0, 1, 8'b0000_0001);
    step(0, 0, 1, 0, 0, 1, 8'h00);

    // Abort: code 5, enable dropped on hold cycle 2, not resumed
    step(0, 0, 1, 1, 5, 1, 8'h00);
    step(0, 0, 1, 0, 5, 0, 8'b0010_0000);
    step(0, 0, 0, 0, 5, 0, 8'b0010_0000);
    step(0, 0, 0, 0, 5, 0, 8'h00);
    step(0, 0, 0, 1, 5, 0, 8'h00);
    step(0, 0, 1, 0, 5, 1, 8'h00);
    step(0, 0, 1, 0, 5, 1, 8'h00);

    // Reset on hold cycle 1 of code 6, then immediate accept of code 2
    step(0, 0, 1, 1, 6, 1, 8'h00);
    step(0, 1, 1, 0, 6, 0, 8'b0100_0000);
    step(0, 0, 1, 1, 2, 1, 8'h00);
    step(0, 0, 1, 0, 2, 0, 8'b0000_0100);
    step(0, 0, 1, 0, 2, 0, 8'b0000_0100);
    step(0, 0, 1, 0, 2, 0, 8'b0000_0100);
    step(0, 0, 1, 0, 2, 1, 8'b0000_0100);
    step(0, 0, 1, 0, 2, 1, 8'h00);

    // HOLD_CYCLES=1: sweep 0..7 then 20 random codes, one word per cycle
    step(2, 1, 1, 0, 0, 0, 8'h00);
    for (int k = 0; k < 8; k++) codes[k] = 3'(k);
    for (int k = 8; k < 28; k++) codes[k] = 3'($urandom_range(0, 7));
    for (int k = 0; k < 28; k++)
      step(1, 0, 1, 1, codes[k], 1, (k == 0) ? 8'h00 : (one << codes[k-1]));
    step(1, 0, 1, 0, 0, 1, one << codes[27]);
    step(1, 0, 1, 0, 0, 1, 8'h00);

    // Let the monitor drain, bounded
    repeat (2) @(negedge clk);
    #3;
    n_vec++;
    if (q4.size() != 0 || q1.size() != 0) begin
      n_err++;
      $display("FAIL drain left q4=%0d q1=%0d want 0", q4.size(), q1.size());
    end
    stim_done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #100000;
    if (!stim_done) begin
      $display("FAIL timeout stimulus incomplete got t=%0t want done", $time);
      $fatal(1, "timeout");
    end
  end

endmodule
